nf_wb_trace_buf: RTL

Hardware retirement-trace buffer on the nanoFOX CPU write-back stage.
- Each cycle the write-back stage retires an instruction, the block captures one record: pc, instr, rd, wdata, register-write flag, cycle stamp and drop count.
- Records are queued in a FIFO and handed to a downstream trace consumer (simulation logger or debug UART bridge) over a valid/ready handshake.
- The block decouples CPU retirement rate from consumer rate without ever stalling the pipeline.

---
 rtl/nf_trace_pkg.sv | 26 ++
 rtl/nf_sync_fifo.sv | 57 +++++
 rtl/nf_wb_trace_buf.sv | 97 +++++++++
 3 files changed

// File: rtl/nf_trace_pkg.sv
// Shared types for the nanoFOX retirement-trace buffer.
// Record layout, MSB to LSB: pc, instr, we_rf, rd, wdata, cycle, lost.
package nf_trace_pkg;

  localparam int unsigned TRACE_CNT_W  = 32;
  localparam int unsigned TRACE_LOST_W = 16;

  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              instr;
    logic                     we_rf;
    logic [4:0]               rd;
    logic [31:0]              wdata;
    logic [TRACE_CNT_W-1:0]   cycle;
    logic [TRACE_LOST_W-1:0]  lost;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);
  // Width of the fields that do not depend on the counter widths.
  localparam int unsigned TRACE_HDR_W = TRACE_REC_W - TRACE_CNT_W - TRACE_LOST_W;

  function automatic int unsigned rec_width(input int unsigned cnt_w, input int unsigned lost_w);
    return TRACE_HDR_W + cnt_w + lost_w;
  endfunction

endpackage

// File: rtl/nf_sync_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush.
// rdata reads as zero while empty so downstream sees clean outputs.
module nf_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clr,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (PtrW + 1)'(Depth));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/nf_wb_trace_buf.sv
// Retirement-trace buffer: captures one record per retired instruction and
// queues it for a valid/ready consumer without ever stalling the pipeline.
module nf_wb_trace_buf
  import nf_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LOST_W = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      trace_en,
  input  logic                      clr,
  input  logic                      wb_valid,
  input  logic [31:0]               wb_pc,
  input  logic [31:0]               wb_instr,
  input  logic                      wb_we_rf,
  input  logic [4:0]                wb_rd,
  input  logic [31:0]               wb_wdata,
  output logic                      tr_valid,
  input  logic                      tr_ready,
  output logic [31:0]               tr_pc,
  output logic [31:0]               tr_instr,
  output logic                      tr_we_rf,
  output logic [4:0]                tr_rd,
  output logic [31:0]               tr_wdata,
  output logic [CNT_W-1:0]          tr_cycle,
  output logic [LOST_W-1:0]         tr_lost,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned RecW = rec_width(CNT_W, LOST_W);

  logic [CNT_W-1:0]  cycle_q;
  logic [LOST_W-1:0] lost_q;
  logic              overflow_q;
  logic              push_req;
  logic              pop_req;
  logic              push_ok;
  logic              full;
  logic              empty;
  logic [RecW-1:0]   rec_in;
  logic [RecW-1:0]   rec_out;

  assign push_req = trace_en & wb_valid;
  assign pop_req  = tr_ready & ~empty;
  assign push_ok  = push_req & (~full | pop_req);

  // rd/wdata are meaningless without a register write, so store them as zero.
  assign rec_in = {wb_pc, wb_instr, wb_we_rf,
                   wb_we_rf ? wb_rd : 5'd0,
                   wb_we_rf ? wb_wdata : 32'd0,
                   cycle_q, lost_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_q <= '0;
    end else if (trace_en) begin
      cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  // The lost count travels with the next accepted record and restarts from zero.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      lost_q     <= '0;
      overflow_q <= 1'b0;
    end else if (push_ok) begin
      lost_q <= '0;
    end else if (push_req) begin
      overflow_q <= 1'b1;
      if (lost_q != '1) lost_q <= lost_q + LOST_W'(1);
    end
  end

  nf_sync_fifo #(
    .Width (RecW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .push   (push_ok),
    .wdata  (rec_in),
    .pop    (pop_req),
    .rdata  (rec_out),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  assign tr_valid = ~empty;
  assign overflow = overflow_q;
  assign {tr_pc, tr_instr, tr_we_rf, tr_rd, tr_wdata, tr_cycle, tr_lost} = rec_out;

endmodule
